// File: rtl/modq_if.sv
// Handshake bundle between the mod-q scheduler, its requesters and the shared reducer.
// The master side is the scheduler; the slave side is the surrounding clients and reducer.
interface modq_if #(
    parameter int N    = 256,
    parameter int NREQ = 4
);
    localparam int GW = ($clog2(NREQ) > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*N-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [N-1:0]      rsp_data;
    logic              rsp_err;
    logic              red_start;
    logic [N-1:0]      red_a;
    logic              red_done;
    logic [N-1:0]      red_b;
    logic              busy;
    logic [GW-1:0]     grant_id;

    modport master (
        input  req_valid, req_data, rsp_ready, red_done, red_b,
        output req_ready, rsp_valid, rsp_data, rsp_err, red_start, red_a, busy, grant_id
    );

    modport slave (
        output req_valid, req_data, rsp_ready, red_done, red_b,
        input  req_ready, rsp_valid, rsp_data, rsp_err, red_start, red_a, busy, grant_id
    );
endinterface

// File: rtl/modq_sched.sv
// Round-robin scheduler sharing one multi-cycle mod-q reducer among NREQ requesters.
// One job in flight at a time; a reducer that never answers is aborted after TIMEOUT cycles
// and the requester receives an error response with zero data.
//
//   state  | meaning
//   IDLE   | waiting for any req_valid; accepts the next requester in round-robin order
//   ISSUE  | pulses red_start for one cycle, clears the timeout timer
//   WAIT   | waiting for red_done or timer expiry
//   RESP   | presenting rsp_valid to the granted requester until it takes the result
module modq_sched #(
    parameter int N       = 256,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 512
) (
    input  logic   clk,
    input  logic   rst_n,
    modq_if.master bus
);
    localparam int GW = ($clog2(NREQ) > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]      state;
    logic [TW-1:0]   timer;
    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   grant_id_q;
    logic [N-1:0]    red_a_q;
    logic [N-1:0]    rsp_data_q;
    logic            rsp_err_q;

    logic [GW-1:0]   pick;
    logic [GW-1:0]   scan_idx;
    logic            pick_found;
    logic [N-1:0]    pick_data;
    logic [NREQ-1:0] grant_onehot;
    logic            grant_ack;

    // Round-robin search starting one past the last served requester.
    always_comb begin
        pick       = '0;
        scan_idx   = '0;
        pick_found = 1'b0;
        for (int off = 1; off <= NREQ; off++) begin
            scan_idx = GW'((int'(last_grant) + off) % NREQ);
            if (!pick_found && ((bus.req_valid >> scan_idx) & NREQ'(1)) != '0) begin
                pick_found = 1'b1;
                pick       = scan_idx;
            end
        end
    end

    // Operand mux for the chosen requester; constant slices keep the select narrow.
    always_comb begin
        pick_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick == GW'(i)) begin
                pick_data = bus.req_data[i*N +: N];
            end
        end
    end

    // Output decode from state and the registered grant.
    always_comb begin
        grant_onehot  = NREQ'(1) << grant_id_q;
        grant_ack     = |(bus.rsp_ready & grant_onehot);
        bus.req_ready = (rst_n && state == S_IDLE && pick_found) ? (NREQ'(1) << pick) : '0;
        bus.rsp_valid = (state == S_RESP) ? grant_onehot : '0;
        bus.red_start = (state == S_ISSUE);
        bus.busy      = (state != S_IDLE);
        bus.red_a     = red_a_q;
        bus.rsp_data  = rsp_data_q;
        bus.rsp_err   = rsp_err_q;
        bus.grant_id  = grant_id_q;
    end

    // Sequencer: accept, launch, wait/timeout, respond. red_done outside WAIT is ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            timer      <= '0;
            last_grant <= GW'(NREQ - 1);
            grant_id_q <= '0;
            red_a_q    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        red_a_q    <= pick_data;
                        grant_id_q <= pick;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    timer <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    timer <= timer + TW'(1);
                    // Completion takes priority over a simultaneous expiry.
                    if (bus.red_done) begin
                        rsp_data_q <= bus.red_b;
                        rsp_err_q  <= 1'b0;
                        state      <= S_RESP;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
                        state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (grant_ack) begin
                        last_grant <= grant_id_q;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
